// File: rtl/pe_input_scheduler.sv
// pe_input_scheduler: streams NUM_PE filter rows onto the NoC, then serves PE window requests round-robin (build option SCHED_STALL_CNT_EN).
// Latency: 2 cycles per packet (memory read strobe, then packet); done pulses one cycle after the final empty arbitration.
// Backpressure: out_packet/out_valid are held while !out_ready; the next memory read is issued only after the handshake.
module pe_input_scheduler #(
    parameter int NUM_PE       = 5,
    parameter int FILTER_SIZE  = 5,
    parameter int IFMAP_SIZE   = 25,
    parameter int PE_BASE_ADDR = 0,
    parameter int W_PKTS       = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  done,
    input  logic [NUM_PE-1:0]     req,
    output logic                  w_rd_en,
    output logic [7:0]            w_rd_addr,
    input  logic [15:0]           w_rd_data,
    output logic                  if_rd_en,
    output logic [4:0]            if_rd_addr,
    input  logic [IFMAP_SIZE-1:0] if_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [29:0]           out_packet
`ifdef SCHED_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int OUTPUT_DIM = IFMAP_SIZE - FILTER_SIZE + 1;
    localparam int NUM_WIN    = OUTPUT_DIM * OUTPUT_DIM;
    localparam int PE_W       = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int WK_W       = (W_PKTS > 1) ? $clog2(W_PKTS) : 1;
    localparam int RC_W       = $clog2(OUTPUT_DIM + 1);
    localparam int CNT_W      = $clog2(NUM_WIN + 1);

    localparam logic [CNT_W-1:0] WIN_TOTAL = CNT_W'(NUM_WIN);
    localparam logic [RC_W-1:0]  COL_LAST  = RC_W'(OUTPUT_DIM - 1);
    localparam logic [PE_W-1:0]  PE_LAST   = PE_W'(NUM_PE - 1);
    localparam logic [WK_W-1:0]  WK_LAST   = WK_W'(W_PKTS - 1);

    typedef struct packed {
        logic [3:0]  dest;
        logic        opcode;
        logic [24:0] data;
    } pkt_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRD,
        S_WSEND,
        S_ARB,
        S_ISEND,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [PE_W-1:0]   wp_q, wp_d;
    logic [WK_W-1:0]   wk_q, wk_d;
    logic [PE_W-1:0]   rr_q, rr_d;
    logic [PE_W-1:0]   gnt_q, gnt_d;
    logic [NUM_PE-1:0] pend_q, pend_d;
    logic [RC_W-1:0]   row_q [NUM_PE];
    logic [RC_W-1:0]   row_d [NUM_PE];
    logic [RC_W-1:0]   col_q [NUM_PE];
    logic [RC_W-1:0]   col_d [NUM_PE];
    logic [CNT_W-1:0]  cnt_q [NUM_PE];
    logic [CNT_W-1:0]  cnt_d [NUM_PE];
    logic              hold_q, hold_d;
    pkt_t              pkt_q, pkt_d;

    pkt_t              live_pkt;
    logic              arb_found;
    logic [PE_W-1:0]   arb_gnt;
    logic              all_done;
    logic [RC_W-1:0]   gnt_row;
    logic [RC_W-1:0]   gnt_col;
    logic [CNT_W-1:0]  gnt_cnt;

    // Round-robin search: first pending PE at or after the pointer, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_gnt   = '0;
        all_done  = 1'b1;
        for (int i = 0; i < NUM_PE; i++) begin
            if (!arb_found && pend_q[(int'(rr_q) + i) % NUM_PE]) begin
                arb_found = 1'b1;
                arb_gnt   = PE_W'((int'(rr_q) + i) % NUM_PE);
            end
            if (cnt_q[i] != WIN_TOTAL) begin
                all_done = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wp_d       = wp_q;
        wk_d       = wk_q;
        rr_d       = rr_q;
        gnt_d      = gnt_q;
        pend_d     = pend_q;
        row_d      = row_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        done       = 1'b0;
        w_rd_en    = 1'b0;
        w_rd_addr  = '0;
        if_rd_en   = 1'b0;
        if_rd_addr = '0;
        out_valid  = 1'b0;
        live_pkt   = '0;
        gnt_row    = row_q[gnt_q];
        gnt_col    = col_q[gnt_q];
        gnt_cnt    = cnt_q[gnt_q];

        if (state_q == S_ARB || state_q == S_ISEND) begin
            for (int p = 0; p < NUM_PE; p++) begin
                if (req[p] && (cnt_q[p] < WIN_TOTAL)) begin
                    pend_d[p] = 1'b1;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WRD;
                    wp_d    = '0;
                    wk_d    = '0;
                end
            end
            S_WRD: begin
                w_rd_en   = 1'b1;
                w_rd_addr = 8'(int'(wp_q) * W_PKTS + int'(wk_q));
                state_d   = S_WSEND;
            end
            S_WSEND: begin
                out_valid       = 1'b1;
                live_pkt.dest   = 4'(PE_BASE_ADDR + int'(wp_q));
                live_pkt.opcode = 1'b0;
                live_pkt.data   = 25'(w_rd_data);
                if (out_ready) begin
                    state_d = S_WRD;
                    if (wk_q == WK_LAST) begin
                        wk_d = '0;
                        if (wp_q == PE_LAST) begin
                            // Every PE starts with one unsolicited window.
                            state_d = S_ARB;
                            pend_d  = '1;
                            rr_d    = '0;
                            for (int p = 0; p < NUM_PE; p++) begin
                                row_d[p] = '0;
                                col_d[p] = '0;
                                cnt_d[p] = '0;
                            end
                        end else begin
                            wp_d = wp_q + 1'b1;
                        end
                    end else begin
                        wk_d = wk_q + 1'b1;
                    end
                end
            end
            S_ARB: begin
                if (arb_found) begin
                    if_rd_en   = 1'b1;
                    if_rd_addr = 5'(int'(row_q[arb_gnt]) + int'(arb_gnt));
                    rr_d       = (arb_gnt == PE_LAST) ? '0 : arb_gnt + 1'b1;
                    gnt_d      = arb_gnt;
                    state_d    = S_ISEND;
                end else if (all_done) begin
                    state_d = S_FIN;
                end
            end
            S_ISEND: begin
                out_valid       = 1'b1;
                live_pkt.dest   = 4'(PE_BASE_ADDR + int'(gnt_q));
                live_pkt.opcode = 1'b1;
                live_pkt.data   = 25'(if_rd_data[gnt_col +: FILTER_SIZE]);
                pend_d[gnt_q]   = 1'b0;
                if (out_ready) begin
                    cnt_d[gnt_q] = gnt_cnt + 1'b1;
                    if (gnt_col == COL_LAST) begin
                        col_d[gnt_q] = '0;
                        row_d[gnt_q] = gnt_row + 1'b1;
                    end else begin
                        col_d[gnt_q] = gnt_col + 1'b1;
                    end
                    // A request landing on our own handshake counts as the next one.
                    if (req[gnt_q] && ((gnt_cnt + 1'b1) < WIN_TOTAL)) begin
                        pend_d[gnt_q] = 1'b1;
                    end
                    state_d = S_ARB;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The first packet cycle forwards the memory word; later stall cycles replay the captured copy.
    always_comb begin
        hold_d     = out_valid && !out_ready;
        pkt_d      = (out_valid && !hold_q) ? live_pkt : pkt_q;
        out_packet = out_valid ? (hold_q ? pkt_q : live_pkt) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wp_q    <= '0;
            wk_q    <= '0;
            rr_q    <= '0;
            gnt_q   <= '0;
            pend_q  <= '0;
            hold_q  <= 1'b0;
            pkt_q   <= '0;
            for (int p = 0; p < NUM_PE; p++) begin
                row_q[p] <= '0;
                col_q[p] <= '0;
                cnt_q[p] <= '0;
            end
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            wk_q    <= wk_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            pend_q  <= pend_d;
            hold_q  <= hold_d;
            pkt_q   <= pkt_d;
            for (int p = 0; p < NUM_PE; p++) begin
                row_q[p] <= row_d[p];
                col_q[p] <= col_d[p];
                cnt_q[p] <= cnt_d[p];
            end
        end
    end

`ifdef SCHED_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pe_input_scheduler.sv
// Directed bench for pe_input_scheduler: weight load, first windows, column wrap, round-robin under backpressure, completion, mid-run reset.
module tb_pe_input_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic [4:0]  req;
    logic        w_rd_en;
    logic [7:0]  w_rd_addr;
    logic [15:0] w_rd_data = '0;
    logic        if_rd_en;
    logic [4:0]  if_rd_addr;
    logic [24:0] if_rd_data = '0;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_packet;
`ifdef SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [24:0] ifm [25];
    logic [29:0] log_q [$];
    logic [4:0]  ga_q [$];
    int          done_cnt = 0;

    int mr [5];
    int mc [5];
    int mcnt [5];
    int mrr;

    pe_input_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .done       (done),
        .req        (req),
        .w_rd_en    (w_rd_en),
        .w_rd_addr  (w_rd_addr),
        .w_rd_data  (w_rd_data),
        .if_rd_en   (if_rd_en),
        .if_rd_addr (if_rd_addr),
        .if_rd_data (if_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_packet (out_packet)
`ifdef SCHED_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous memories: data appears the cycle after the strobe and holds otherwise.
    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= 16'hA53C + {8'h00, w_rd_addr};
        if (if_rd_en) if_rd_data <= ifm[if_rd_addr];
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) log_q.push_back(out_packet);
            if (if_rd_en) ga_q.push_back(if_rd_addr);
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(tag, (log_q.size() >= n) ? 64'd1 : 64'd0, 64'd1);
    endtask

    function automatic logic [29:0] exp_in(input int p);
        logic [24:0] row;
        row = ifm[mr[p] + p];
        return {4'(p), 1'b1, 20'b0, row[mc[p] +: 5]};
    endfunction

    function automatic logic [29:0] exp_w(input int i);
        logic [15:0] d;
        d = 16'hA53C + 16'(i);
        return {4'(i / 3), 1'b0, 9'b0, d};
    endfunction

    task automatic adv(input int p);
        mcnt[p]++;
        if (mc[p] == 20) begin
            mc[p] = 0;
            mr[p]++;
        end else begin
            mc[p]++;
        end
        mrr = (p + 1) % 5;
    endtask

    function automatic int next_gnt();
        for (int i = 0; i < 5; i++) begin
            if (mcnt[(mrr + i) % 5] < 441) return (mrr + i) % 5;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 5; p++) begin
            mr[p] = 0; mc[p] = 0; mcnt[p] = 0;
        end
        mrr = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int base, base2, k, g, bad, sz;
        int pe_n [5];
        logic [29:0] e;
        logic [29:0] pk;

        reset = 1'b1; start = 1'b0; req = '0; out_ready = 1'b0;
        ifm[0] = 25'h1F;
        ifm[1] = 25'h0;
        for (int r = 2; r < 25; r++) ifm[r] = 25'((r * 32'h001357A1) ^ 32'h01555AAA);
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_w_rd_en", w_rd_en, 0);
        chk("rst_if_rd_en", if_rd_en, 0);
        chk("rst_out_packet", out_packet, 0);
        chk("rst_w_rd_addr", w_rd_addr, 0);
        chk("rst_if_rd_addr", if_rd_addr, 0);
`ifdef SCHED_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        step();

        // Weight load: 15 packets, PE order 0,0,0,1,1,1,...
        pulse_start();
        wait_log(15, 100, "w_timeout");
        for (int i = 0; i < 15; i++) chk("w_pkt", log_q[i], exp_w(i));
        chk("w_first", log_q[0], {4'd0, 1'b0, 9'b0, 16'hA53C});

        // Unsolicited first windows, grant order 0..4
        wait_log(20, 100, "win0_timeout");
        pk = log_q[15];
        chk("pe0_ones", pk[4:0], 5'b11111);
        pk = log_q[16];
        chk("pe1_zero", pk[4:0], 5'b00000);
        for (int p = 0; p < 5; p++) begin
            chk("win0_pkt", log_q[15 + p], exp_in(p));
            chk("win0_addr", ga_q[p], 5'(p));
            adv(p);
        end
        pulse_start();
        repeat (10) step();
        chk("quiet_no_req", log_q.size(), 20);

        // PE2 column wrap after 21 handshakes
        for (int n = 1; n <= 21; n++) begin
            req = 5'b00100;
            step();
            req = '0;
            wait_log(20 + n, 20, "pe2_timeout");
            chk("pe2_win", log_q[20 + n - 1], exp_in(2));
            if (n == 21) chk("wrap_addr", ga_q[ga_q.size() - 1], 5'd3);
            adv(2);
        end

        // Round robin under backpressure
        base = log_q.size();
        out_ready = 1'b0;
        req = 5'h1F;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        e = exp_in(next_gnt());
        chk("bp_valid", out_valid, 1);
        chk("bp_hold0", out_packet, e);
        @(negedge clk);
        chk("bp_hold1", out_packet, e);
        chk("bp_valid1", out_valid, 1);
        @(negedge clk);
        chk("bp_hold2", out_packet, e);
        step();
        out_ready = 1'b1;
        wait_log(base + 6, 40, "bp_timeout");
        req = '0;
        repeat (20) step();
        for (int i = base; i < log_q.size(); i++) begin
            g = next_gnt();
            chk("rr_pkt", log_q[i], (g < 0) ? 30'h3FFFFFFF : exp_in(g));
            if (g >= 0) adv(g);
        end
`ifdef SCHED_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 3);
`endif

        // Completion: keep requesting until every PE has 441 windows
        base = log_q.size();
        req = 5'h1F;
        k = 0;
        while (done_cnt == 0 && k < 10000) begin
            step();
            k++;
        end
        chk("done_seen", done_cnt, 1);
        sz = log_q.size();
        repeat (30) step();
        chk("done_once", done_cnt, 1);
        chk("no_extra_pkts", log_q.size(), sz);
        req = '0;
        bad = 0;
        for (int i = base; i < log_q.size(); i++) begin
            g = next_gnt();
            if (g < 0) bad++;
            else begin
                if (log_q[i] !== exp_in(g)) bad++;
                adv(g);
            end
        end
        chk("run_pkts_bad", bad, 0);
        for (int p = 0; p < 5; p++) pe_n[p] = 0;
        for (int i = 15; i < log_q.size(); i++) begin
            pk = log_q[i];
            if (pk[25] && pk[29:26] < 4'd5) pe_n[pk[29:26]]++;
        end
        for (int p = 0; p < 5; p++) chk("pe_total", pe_n[p], 441);

        // Reset mid-run with a packet held, then a clean restart
        model_reset();
        base = log_q.size();
        out_ready = 1'b1;
        pulse_start();
        wait_log(base + 15, 100, "rs_w_timeout");
        out_ready = 1'b0;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rs_pre_valid", out_valid, 1);
        #1 reset = 1'b1;
        #1;
        chk("rs_out_valid", out_valid, 0);
        chk("rs_done", done, 0);
        chk("rs_out_packet", out_packet, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rs_idle_w_rd_en", w_rd_en, 0);
        chk("rs_idle_valid", out_valid, 0);
        step();
        base2 = log_q.size();
        out_ready = 1'b1;
        pulse_start();
        wait_log(base2 + 16, 100, "rs_run_timeout");
        chk("rs_w_first", log_q[base2], exp_w(0));
        chk("rs_w_last", log_q[base2 + 14], exp_w(14));
        chk("rs_win_pe0", log_q[base2 + 15], exp_in(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
